// File: rtl/mcont_arb_pkg.sv
// Shared definitions for the memory-controller channel arbiter: FSM encoding and size limits.
package mcont_arb_pkg;

  localparam int unsigned MAX_CHN       = 16;
  localparam int unsigned DEF_CHN_WIDTH = 4;

  typedef enum logic [1:0] {
    StIdle,
    StArb,
    StStart,
    StBusy
  } arb_state_e;

endpackage

// File: rtl/mcont_rr_pick.sv
// Combinational round-robin picker: first set request after rr_last, wrapping modulo NUM_CHN.
module mcont_rr_pick #(
  parameter int unsigned NUM_CHN   = 16,
  parameter int unsigned CHN_WIDTH = 4
) (
  input  logic [NUM_CHN-1:0]   req,
  input  logic [CHN_WIDTH-1:0] rr_last,
  output logic                 found,
  output logic [CHN_WIDTH-1:0] index
);

  // Walk the rotated order backwards so the nearest candidate after rr_last is written last.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = NUM_CHN; i >= 1; i--) begin
      if (req[(32'(rr_last) + 32'(i)) % NUM_CHN]) begin
        found = 1'b1;
        index = CHN_WIDTH'((32'(rr_last) + 32'(i)) % NUM_CHN);
      end
    end
  end

endmodule

// File: rtl/mcont_chn_arbiter.sv
// Round-robin scheduler sharing one sequencer between channels.
// Define MCONTR_ARB_PRIORITY_EN for two-level (urgent first) arbitration.
module mcont_chn_arbiter
  import mcont_arb_pkg::*;
#(
  parameter int unsigned NUM_CHN   = 16,
  parameter int unsigned CHN_WIDTH = DEF_CHN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CHN-1:0]   chn_en,
  input  logic [NUM_CHN-1:0]   want_rq,
  input  logic [NUM_CHN-1:0]   urgent_rq,
  input  logic                 seq_done,
  output logic [NUM_CHN-1:0]   grant,
  output logic [CHN_WIDTH-1:0] run_chn,
  output logic                 run_start,
  output logic                 busy,
  output logic                 done_err
);

  arb_state_e           state_q, state_d;
  logic [NUM_CHN-1:0]   grant_q, grant_d;
  logic [CHN_WIDTH-1:0] run_chn_q, run_chn_d;
  logic [CHN_WIDTH-1:0] rr_last_q, rr_last_d;
  logic                 run_start_q, run_start_d;
  logic                 busy_q, busy_d;
  logic                 done_err_q, done_err_d;

  logic [NUM_CHN-1:0]   elig, pick_req;
  logic                 pick_found;
  logic [CHN_WIDTH-1:0] pick_idx;

  assign elig = want_rq & chn_en;

`ifdef MCONTR_ARB_PRIORITY_EN
  logic [NUM_CHN-1:0] urg_elig;
  assign urg_elig = elig & urgent_rq;
  assign pick_req = (|urg_elig) ? urg_elig : elig;
`else
  logic unused_urgent;
  assign unused_urgent = ^urgent_rq;
  assign pick_req      = elig;
`endif

  mcont_rr_pick #(
    .NUM_CHN   (NUM_CHN),
    .CHN_WIDTH (CHN_WIDTH)
  ) u_pick (
    .req     (pick_req),
    .rr_last (rr_last_q),
    .found   (pick_found),
    .index   (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = '0;
    run_start_d = 1'b0;
    run_chn_d   = run_chn_q;
    rr_last_d   = rr_last_q;
    busy_d      = busy_q;
    done_err_d  = done_err_q | (seq_done & ~busy_q);
    unique case (state_q)
      StIdle: begin
        if (|elig) state_d = StArb;
      end
      StArb: begin
        if (pick_found) begin
          grant_d     = NUM_CHN'(1) << pick_idx;
          run_start_d = 1'b1;
          busy_d      = 1'b1;
          run_chn_d   = pick_idx;
          rr_last_d   = pick_idx;
          state_d     = StStart;
        end else begin
          state_d = StIdle;
        end
      end
      // busy is already high here, so an early seq_done completes the sequence
      StStart: begin
        if (seq_done) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (seq_done) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      run_start_q <= 1'b0;
      run_chn_q   <= '0;
      rr_last_q   <= CHN_WIDTH'(NUM_CHN - 1);
      busy_q      <= 1'b0;
      done_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      run_start_q <= run_start_d;
      run_chn_q   <= run_chn_d;
      rr_last_q   <= rr_last_d;
      busy_q      <= busy_d;
      done_err_q  <= done_err_d;
    end
  end

  assign grant     = grant_q;
  assign run_chn   = run_chn_q;
  assign run_start = run_start_q;
  assign busy      = busy_q;
  assign done_err  = done_err_q;

endmodule

// File: tb/tb_mcont_chn_arbiter.sv
// Self-checking bench for mcont_chn_arbiter: vector table plus multi-cycle scenarios.
module tb_mcont_chn_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] chn_en, want_rq, urgent_rq;
  logic        seq_done;
  logic [15:0] grant;
  logic [3:0]  run_chn;
  logic        run_start, busy, done_err;

  int checks   = 0;
  int failures = 0;
  int unsigned exp_q[$];

  typedef struct {
    logic [15:0] want;
    logic [15:0] en;
    logic [15:0] urg;
    logic        found;
    int unsigned chn;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  mcont_chn_arbiter #(
    .NUM_CHN   (16),
    .CHN_WIDTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .chn_en    (chn_en),
    .want_rq   (want_rq),
    .urgent_rq (urgent_rq),
    .seq_done  (seq_done),
    .grant     (grant),
    .run_chn   (run_chn),
    .run_start (run_start),
    .busy      (busy),
    .done_err  (done_err)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    chn_en    = 16'hFFFF;
    want_rq   = '0;
    urgent_rq = '0;
    seq_done  = 1'b0;
    exp_q.delete();
    step();
    step();
    chk("reset outputs", {grant, run_chn, run_start, busy, done_err}, 32'h0);
    rst_n = 1'b1;
    step();
  endtask

  // Wait for run_start, compare against the scoreboard, hold BUSY, optionally raise seq_done.
  task automatic run_one(input string nm, input int lat_exp, input int hold,
                         input bit keep_req, input bit do_done);
    int n;
    int unsigned e;
    n = 0;
    do begin
      step();
      n++;
      if (n == 1) seq_done = 1'b0;
    end while (!run_start && n < 12);
    chk({nm, " latency"}, n, lat_exp);
    if (!run_start) return;
    if (exp_q.size() == 0) begin
      chk({nm, " unexpected grant"}, {16'h0, grant}, 32'h0);
      return;
    end
    e = exp_q.pop_front();
    chk({nm, " grant"}, {16'h0, grant}, 32'h1 << e);
    chk({nm, " run_chn"}, run_chn, e);
    chk({nm, " busy on start"}, busy, 1);
    if (!keep_req) want_rq = want_rq & ~grant;
    repeat (hold) step();
    chk({nm, " run_chn held"}, {run_chn, busy}, {e[3:0], 1'b1});
    if (do_done) seq_done = 1'b1;
  endtask

  task automatic end_seq(input string nm);
    step();
    seq_done = 1'b0;
    chk({nm, " busy drop"}, busy, 0);
  endtask

  task automatic watch_idle(input string nm, input int cycles);
    int starts;
    starts = 0;
    repeat (cycles) begin
      step();
      seq_done = 1'b0;
      if (run_start) starts++;
    end
    chk({nm, " no grant"}, starts, 0);
  endtask

  initial begin
    vecs[0] = '{16'h0001, 16'hFFFF, 16'h0000, 1'b1, 0};
    vecs[1] = '{16'h8000, 16'hFFFF, 16'h0000, 1'b1, 15};
    vecs[2] = '{16'h0006, 16'hFFFF, 16'h0000, 1'b1, 1};
    vecs[3] = '{16'h0003, 16'hFFFE, 16'h0000, 1'b1, 1};
`ifdef MCONTR_ARB_PRIORITY_EN
    vecs[4] = '{16'h00F0, 16'hFFFF, 16'h0080, 1'b1, 7};
`else
    vecs[4] = '{16'h00F0, 16'hFFFF, 16'h0080, 1'b1, 4};
`endif
    vecs[5] = '{16'h0000, 16'hFFFF, 16'h0000, 1'b0, 0};
    vecs[6] = '{16'h0010, 16'h0000, 16'h0000, 1'b0, 0};
    vecs[7] = '{16'h0C00, 16'h0800, 16'hFFFF, 1'b1, 11};

    for (int i = 0; i < 8; i++) begin
      do_reset();
      want_rq   = vecs[i].want;
      chn_en    = vecs[i].en;
      urgent_rq = vecs[i].urg;
      if (vecs[i].found) begin
        exp_q.push_back(vecs[i].chn);
        run_one($sformatf("vec%0d", i), 2, 2, 1'b0, 1'b1);
        end_seq($sformatf("vec%0d", i));
      end else begin
        watch_idle($sformatf("vec%0d", i), 6);
      end
    end

    // Basic latency and seq_done 5 cycles after run_start.
    do_reset();
    want_rq = 16'h0001;
    exp_q.push_back(0);
    run_one("t1", 2, 5, 1'b0, 1'b1);
    end_seq("t1");

    // Round robin with back-to-back sequences.
    do_reset();
    want_rq = 16'h8421;
    exp_q = '{0, 5, 10, 15, 0};
    run_one("t2 g0", 2, 3, 1'b1, 1'b1);
    for (int k = 1; k < 5; k++) run_one($sformatf("t2 g%0d", k), 3, 3, 1'b1, 1'b1);
    want_rq = '0;
    end_seq("t2");

    // Disabled channel never wins; dropping chn_en in BUSY still completes.
    do_reset();
    want_rq = 16'h0003;
    chn_en  = 16'hFFFE;
    exp_q   = '{1, 1};
    run_one("t3 a", 2, 2, 1'b1, 1'b1);
    run_one("t3 b", 3, 2, 1'b1, 1'b0);
    chn_en = '0;
    step();
    chk("t3 busy kept", busy, 1);
    seq_done = 1'b1;
    end_seq("t3");
    watch_idle("t3", 8);

    // Stray seq_done in IDLE.
    do_reset();
    seq_done = 1'b1;
    step();
    seq_done = 1'b0;
    chk("t4 done_err", {done_err, busy, run_start}, 3'b100);
    want_rq = 16'h0004;
    exp_q.push_back(2);
    run_one("t4", 2, 2, 1'b0, 1'b1);
    end_seq("t4");
    chk("t4 done_err sticky", done_err, 1);

    // Reset in the middle of BUSY.
    do_reset();
    seq_done = 1'b1;
    step();
    seq_done = 1'b0;
    want_rq = 16'h0009;
    exp_q.push_back(0);
    run_one("t5", 2, 2, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t5 async reset", {grant, run_chn, run_start, busy, done_err}, 32'h0);
    step();
    rst_n = 1'b1;
    exp_q.push_back(0);
    run_one("t5 regrant", 2, 2, 1'b0, 1'b1);
    end_seq("t5");

    // Urgent qualifier.
    do_reset();
    want_rq   = 16'h00F0;
    urgent_rq = 16'h0080;
`ifdef MCONTR_ARB_PRIORITY_EN
    exp_q = '{7, 4, 5, 6};
`else
    exp_q = '{4, 5, 6, 7};
`endif
    run_one("t6 g0", 2, 2, 1'b0, 1'b1);
    for (int k = 1; k < 4; k++) run_one($sformatf("t6 g%0d", k), 3, 2, 1'b0, 1'b1);
    end_seq("t6");
    watch_idle("t6", 5);
    chk("t6 scoreboard empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
